bcd_converter_seq: RTL and testbench

//  Multi-cycle, parametrised binary-to-BCD converter: iterative double-dabble, one bit per clock.

---
 rtl/bcd_converter_seq_pkg.sv | 19 +
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/bcd_converter_seq.sv | 111 +++++++++++
 tb/tb_bcd_converter_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_converter_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and a digit-count helper for instantiators.
package bcd_converter_seq_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Decimal digits needed for 2**width-1: floor(width*log10(2))+1. Exact because
  // 2**width is never a power of ten.
  function automatic int bcd_digits_for(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adjust
  import bcd_converter_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= BCD_DIGIT_W'(5)) ? digit + BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_converter_seq.sv
// Iterative double-dabble binary-to-BCD converter, one operand bit per clock,
// with optional two's-complement input and an overflow flag for too few digits.
module bcd_converter_seq
  import bcd_converter_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGITS    = 5,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              binary,
  input  logic                          is_signed,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          negative,
  output logic                          overflow,
  output logic                          busy,
  output logic                          done
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state, state_nx;
  logic [WIDTH-1:0] operand;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adjusted;
  logic [CW-1:0]    cnt;
  logic             neg_r;
  logic             ovf_r;
  logic             accept;
  logic             negate;
  logic             last_shift;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (work[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adjusted[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A negative operand is converted as its unsigned magnitude, so -2**(WIDTH-1) works.
  assign negate     = SIGNED_EN && is_signed && binary[WIDTH-1];
  assign last_shift = (state == ST_CONV) && (cnt == CW'(1));

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_CONV;
        end
      end
      ST_CONV: begin
        if (cnt == CW'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_CONV;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because reset must clear the visible
  // result outputs and a fully defined work register keeps simulation X-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      operand  <= '0;
      work     <= '0;
      cnt      <= '0;
      neg_r    <= 1'b0;
      ovf_r    <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        operand <= negate ? ({WIDTH{1'b0}} - binary) : binary;
        neg_r   <= negate;
        work    <= '0;
        ovf_r   <= 1'b0;
        cnt     <= CW'(WIDTH);
      end else if (state == ST_CONV) begin
        // Adjusted digits and operand shift left together as one long register.
        {work, operand} <= {adjusted[BW-2:0], operand, 1'b0};
        ovf_r           <= ovf_r | adjusted[BW-1];
        cnt             <= cnt - CW'(1);
        if (last_shift) begin
          bcd      <= {adjusted[BW-2:0], operand[WIDTH-1]};
          negative <= neg_r;
          overflow <= ovf_r | adjusted[BW-1];
        end
      end
    end
  end

  assign busy = (state == ST_CONV);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed self-checking bench for bcd_converter_seq: three instances cover
// 5 digits signed, 3 digits (overflow) and SIGNED_EN=0.
module tb_bcd_converter_seq;
  import bcd_converter_seq_pkg::*;

  localparam int W  = 16;
  localparam int D5 = bcd_digits_for(W);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [W-1:0] binary = '0;
  logic        is_signed = 1'b0;
  logic [19:0] bcd5;
  logic [11:0] bcd3;
  logic [19:0] bcdu;
  logic [2:0]  neg, ovf, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_converter_seq #(.WIDTH(W), .DIGITS(D5), .SIGNED_EN(1'b1)) u_d5 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .binary(binary), .is_signed(is_signed),
    .bcd(bcd5), .negative(neg[0]), .overflow(ovf[0]), .busy(busy[0]), .done(done[0])
  );

  bcd_converter_seq #(.WIDTH(W), .DIGITS(3), .SIGNED_EN(1'b1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .binary(binary), .is_signed(is_signed),
    .bcd(bcd3), .negative(neg[1]), .overflow(ovf[1]), .busy(busy[1]), .done(done[1])
  );

  bcd_converter_seq #(.WIDTH(W), .DIGITS(5), .SIGNED_EN(1'b0)) u_us (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .binary(binary), .is_signed(is_signed),
    .bcd(bcdu), .negative(neg[2]), .overflow(ovf[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on instance k for one cycle and wait (bounded) for its done.
  // lat = cycles from the start cycle to the done cycle.
  task automatic run_conv(input int k, input logic [W-1:0] b, input logic s, output int lat);
    binary    = b;
    is_signed = s;
    start[k]  = 1'b1;
    tick();
    start[k]  = 1'b0;
    lat = 1;
    while (done[k] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int busy_seen;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_bcd", 32'(bcd5), 32'h0);
    check("reset_neg", 32'(neg[0]), 32'h0);
    check("reset_ovf", 32'(ovf[0]), 32'h0);
    check("reset_busy", 32'(busy[0]), 32'h0);
    check("reset_done", 32'(done[0]), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1. Unsigned full scale, latency 17
    run_conv(0, 16'hFFFF, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd17);
    check("t1_bcd", 32'(bcd5), 32'h65535);
    check("t1_ovf", 32'(ovf[0]), 32'h0);
    check("t1_neg", 32'(neg[0]), 32'h0);
    check("t1_busy_in_done", 32'(busy[0]), 32'h0);
    tick();
    check("t1_done_one_cycle", 32'(done[0]), 32'h0);
    check("t1_bcd_hold", 32'(bcd5), 32'h65535);

    // 2. Signed operands
    run_conv(0, 16'h8000, 1'b1, lat);
    check("t2_min_bcd", 32'(bcd5), 32'h32768);
    check("t2_min_neg", 32'(neg[0]), 32'h1);
    run_conv(0, 16'hFFFF, 1'b1, lat);
    check("t2_m1_bcd", 32'(bcd5), 32'h00001);
    check("t2_m1_neg", 32'(neg[0]), 32'h1);
    run_conv(0, 16'h7FFF, 1'b1, lat);
    check("t2_max_bcd", 32'(bcd5), 32'h32767);
    check("t2_max_neg", 32'(neg[0]), 32'h0);
    run_conv(0, 16'h0000, 1'b1, lat);
    check("t2_zero_bcd", 32'(bcd5), 32'h00000);
    check("t2_zero_neg", 32'(neg[0]), 32'h0);

    // 3. start during CONV is ignored
    binary    = 16'h1234;
    is_signed = 1'b0;
    start[0]  = 1'b1;
    tick();
    start[0]  = 1'b0;
    check("t3_busy", 32'(busy[0]), 32'h1);
    repeat (4) tick();
    binary   = 16'h0007;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    lat = 6;
    while (done[0] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("t3_latency", 32'(lat), 32'd17);
    check("t3_bcd", 32'(bcd5), 32'h04660);
    pulses = 0;
    busy_seen = 0;
    repeat (20) begin
      tick();
      if (done[0] === 1'b1) pulses++;
      if (busy[0] === 1'b1) busy_seen++;
    end
    check("t3_no_second_done", 32'(pulses), 32'd0);
    check("t3_no_second_conv", 32'(busy_seen), 32'd0);

    // 4. Three digits: truncation and overflow
    run_conv(1, 16'd1234, 1'b0, lat);
    check("t4_1234_ovf", 32'(ovf[1]), 32'h1);
    check("t4_1234_bcd", 32'(bcd3), 32'h234);
    run_conv(1, 16'd999, 1'b0, lat);
    check("t4_999_ovf", 32'(ovf[1]), 32'h0);
    check("t4_999_bcd", 32'(bcd3), 32'h999);
    run_conv(1, 16'd1000, 1'b0, lat);
    check("t4_1000_ovf", 32'(ovf[1]), 32'h1);
    check("t4_1000_bcd", 32'(bcd3), 32'h000);
    run_conv(1, 16'hFFFF, 1'b1, lat);
    check("t4_m1_neg", 32'(neg[1]), 32'h1);
    check("t4_m1_bcd", 32'(bcd3), 32'h001);

    // 5. Reset at CONV cycle 8 aborts with no done
    binary   = 16'h270F;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (7) tick();
    check("t5_busy_before_rst", 32'(busy[0]), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rst_bcd", 32'(bcd5), 32'h0);
    check("t5_rst_flags", 32'({neg[0], ovf[0], busy[0], done[0]}), 32'h0);
    pulses = 0;
    repeat (25) begin
      tick();
      if (done[0] === 1'b1) pulses++;
    end
    check("t5_no_done", 32'(pulses), 32'd0);
    run_conv(0, 16'h270F, 1'b0, lat);
    check("t5_latency", 32'(lat), 32'd17);
    check("t5_bcd", 32'(bcd5), 32'h09999);

    // 6. start held high: one result every 17 cycles
    binary    = 16'd0;
    is_signed = 1'b0;
    start[0]  = 1'b1;
    tick();
    lat = 1;
    while (done[0] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("t6_first_latency", 32'(lat), 32'd17);
    check("t6_first_bcd", 32'(bcd5), 32'h00000);
    binary = 16'd42;
    tick();
    check("t6_back_to_back_busy", 32'(busy[0]), 32'h1);
    lat = 1;
    while (done[0] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("t6_period", 32'(lat), 32'd17);
    check("t6_second_bcd", 32'(bcd5), 32'h00042);
    start[0] = 1'b0;
    tick();
    check("t6_idle_after", 32'({busy[0], done[0]}), 32'h0);

    // SIGNED_EN=0 ignores is_signed
    run_conv(2, 16'hFFFF, 1'b1, lat);
    check("us_latency", 32'(lat), 32'd17);
    check("us_bcd", 32'(bcdu), 32'h65535);
    check("us_neg", 32'(neg[2]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
